// File: rtl/ysyx_axi4_sram_slave_if.sv
// rtl/ysyx_axi4_sram_slave_if.sv - AXI4 read/write channel bundle between core master and SRAM responder
interface ysyx_axi4_sram_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [3:0]          arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [3:0]          rid;
    logic [1:0]          rresp;
    logic [DATA_W-1:0]   rdata;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [3:0]          awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport slave (
        input  arid, arlen, arsize, arburst, araddr, arvalid,
        output arready,
        output rid, rresp, rdata, rlast, rvalid,
        input  rready,
        input  awid, awlen, awsize, awburst, awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, arlen, arsize, arburst, araddr, arvalid,
        input  arready,
        input  rid, rresp, rdata, rlast, rvalid,
        output rready,
        output awid, awlen, awsize, awburst, awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/ysyx_axi4_sram_slave.sv
// rtl/ysyx_axi4_sram_slave.sv - AXI4 responder over a word-addressed SRAM with independent read/write FSMs
module ysyx_axi4_sram_slave #(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 64,
    parameter int                DEPTH  = 65536,
    parameter logic [ADDR_W-1:0] BASE   = 32'h80000000,
    parameter int                RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_axi4_sram_slave_if.slave     bus
);
    localparam int         AW_IDX = $clog2(DEPTH);
    localparam int         NB     = DATA_W / 8;
    localparam logic [3:0] LAT_M1 = 4'(RD_LAT > 0 ? RD_LAT - 1 : 0);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ((a - BASE) >> (AW_IDX + 3)) == '0;
    endfunction

    function automatic logic [AW_IDX-1:0] idx(input logic [ADDR_W-1:0] a);
        return AW_IDX'((a - BASE) >> 3);
    endfunction

    // FIXED repeats the start address; any other burst code advances by the beat size
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (ADDR_W'(1) << size);
    endfunction

    // ready outputs stay low until the first clock after reset release
    logic live;

    // live flag: set one cycle after reset deasserts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) live <= 1'b0;
        else      live <= 1'b1;
    end

    r_state_t          r_state, r_state_n;
    logic [3:0]        r_id, r_cnt;
    logic [ADDR_W-1:0] r_addr, r_addr_nx, r_sample_addr;
    logic [7:0]        r_len, r_beat;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [DATA_W-1:0] r_data;
    logic              r_err, r_last, ar_hs, r_hs, r_sample;

    // read state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_state_n;
    end

    // read next state, handshakes and sample strobe; with zero latency the next word is sampled on the accepting edge
    always_comb begin
        r_state_n     = r_state;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        ar_hs         = 1'b0;
        r_hs          = 1'b0;
        r_sample      = 1'b0;
        r_last        = (r_beat == r_len);
        r_addr_nx     = next_addr(r_addr, r_size, r_burst);
        r_sample_addr = r_addr;
        case (r_state)
            R_IDLE: begin
                bus.arready   = live;
                ar_hs         = live & bus.arvalid;
                r_sample_addr = bus.araddr;
                if (ar_hs) begin
                    if (RD_LAT == 0) begin
                        r_sample  = 1'b1;
                        r_state_n = R_DATA;
                    end else begin
                        r_state_n = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == 4'd0) begin
                    r_sample  = 1'b1;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                bus.rvalid    = 1'b1;
                r_hs          = bus.rready;
                r_sample_addr = r_addr_nx;
                if (r_hs) begin
                    if (r_last)           r_state_n = R_IDLE;
                    else if (RD_LAT == 0) r_sample  = 1'b1;
                    else                  r_state_n = R_WAIT;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // read burst bookkeeping and data capture; the memory sample sees pre-write contents on a collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id    <= bus.arid;
                r_addr  <= bus.araddr;
                r_len   <= bus.arlen;
                r_size  <= bus.arsize;
                r_burst <= bus.arburst;
                r_beat  <= '0;
                r_cnt   <= LAT_M1;
            end else if (r_hs && !r_last) begin
                r_addr  <= r_addr_nx;
                r_beat  <= r_beat + 8'd1;
                r_cnt   <= LAT_M1;
            end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
                r_cnt   <= r_cnt - 4'd1;
            end
            if (r_sample) begin
                r_err  <= !in_range(r_sample_addr);
                r_data <= in_range(r_sample_addr) ? mem[idx(r_sample_addr)] : '0;
            end
        end
    end

    assign bus.rid   = r_id;
    assign bus.rdata = r_data;
    assign bus.rresp = {r_err, 1'b0};
    assign bus.rlast = (r_state == R_DATA) && r_last;

    w_state_t          w_state, w_state_n;
    logic [3:0]        w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [8:0]        w_beat;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err, aw_hs, w_hs, w_do_write;

    // write state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) w_state <= W_IDLE;
        else      w_state <= w_state_n;
    end

    // write next state and handshakes; W is only accepted once AW has been taken
    always_comb begin
        w_state_n   = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.awready = live;
                aw_hs       = live & bus.awvalid;
                if (aw_hs) w_state_n = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                w_hs       = bus.wvalid;
                if (w_hs && bus.wlast) w_state_n = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
        w_do_write = w_hs && in_range(w_addr) && (w_beat <= {1'b0, w_len});
    end

    // write burst bookkeeping; error is sticky for out-of-range beats and a wlast off the expected beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= bus.awid;
            w_addr  <= bus.awaddr;
            w_len   <= bus.awlen;
            w_size  <= bus.awsize;
            w_burst <= bus.awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_addr  <= next_addr(w_addr, w_size, w_burst);
            if (w_beat != '1) w_beat <= w_beat + 9'd1;
            w_err   <= w_err | !in_range(w_addr) | (bus.wlast && w_beat != {1'b0, w_len});
        end
    end

    // byte-lane memory write; contents are never cleared by reset
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wstrb[i]) mem[idx(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.bid   = w_id;
    assign bus.bresp = (w_state == W_RESP && w_err) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_ysyx_axi4_sram_slave.sv
// tb/tb_ysyx_axi4_sram_slave.sv - scoreboard bench for the AXI4 SRAM responder
module tb_ysyx_axi4_sram_slave;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_axi4_sram_slave_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    ysyx_axi4_sram_slave #(.ADDR_W(32), .DATA_W(64), .DEPTH(65536),
                           .BASE(32'h80000000), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;
    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    r_exp_t exp_r[$];
    b_exp_t exp_b[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int t_ar = 0;
    int t_rv = 0;
    int rr_mode = 2;

    logic [63:0] d2 [4];
    logic [63:0] word0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_r(input logic [63:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
        r_exp_t e;
        e.data = d; e.resp = resp; e.last = last; e.id = id;
        exp_r.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] resp, input logic [3:0] id);
        b_exp_t e;
        e.resp = resp; e.id = id;
        exp_b.push_back(e);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 200);
        chk("ar_accept", {63'd0, bus.arready}, 64'd1);
        t_ar = cyc;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 200);
        chk("aw_accept", {63'd0, bus.awready}, 64'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
        int n;
        bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wready && n < 200);
        chk("w_accept", {63'd0, bus.wready}, 64'd1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 1000) begin
            @(posedge clk); n++;
        end
        #1;
        chk(name, 64'(exp_r.size() + exp_b.size()), 64'd0);
    endtask

    task automatic wait_rvalid(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rvalid && n < 200);
        chk(name, {63'd0, bus.rvalid}, 64'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk); #1;
        if (rr_mode == 0)      bus.rready = 1'b1;
        else if (rr_mode == 1) bus.rready = !bus.rready;
    end

    // monitor: compare every R and B handshake against the scoreboard and check R payload holds while stalled
    initial begin
        logic        hold_pend;
        logic [63:0] hold_data;
        logic        hold_last;
        logic        rv_prev;
        r_exp_t      er;
        b_exp_t      eb;
        hold_pend = 1'b0; hold_data = '0; hold_last = 1'b0; rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rvalid && !rv_prev) t_rv = cyc;
            rv_prev = bus.rvalid;
            if (rst && bus.rvalid) begin
                if (hold_pend) begin
                    chk("r_hold_data", bus.rdata, hold_data);
                    chk("r_hold_last", {63'd0, bus.rlast}, {63'd0, hold_last});
                end
                if (bus.rready) begin
                    hold_pend = 1'b0;
                    if (exp_r.size() == 0) begin
                        n_total++;
                        $display("FAIL r_unexpected: got beat %h expected none", bus.rdata);
                    end else begin
                        er = exp_r.pop_front();
                        chk("r_data", bus.rdata, er.data);
                        chk("r_resp", {62'd0, bus.rresp}, {62'd0, er.resp});
                        chk("r_last", {63'd0, bus.rlast}, {63'd0, er.last});
                        chk("r_id", {60'd0, bus.rid}, {60'd0, er.id});
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_data = bus.rdata;
                    hold_last = bus.rlast;
                end
            end else begin
                hold_pend = 1'b0;
            end
            if (rst && bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) begin
                    n_total++;
                    $display("FAIL b_unexpected: got bresp %h expected none", bus.bresp);
                end else begin
                    eb = exp_b.pop_front();
                    chk("b_resp", {62'd0, bus.bresp}, {62'd0, eb.resp});
                    chk("b_id", {60'd0, bus.bid}, {60'd0, eb.id});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.arid = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.rready = 1'b0; bus.bready = 1'b1;
        d2[0] = 64'h0123456789ABCDEF; d2[1] = 64'hFEDCBA9876543210;
        d2[2] = 64'hA5A5A5A55A5A5A5A; d2[3] = 64'h0F0F0F0FF0F0F0F0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", {63'd0, bus.arready}, 64'd0);
        chk("rst_awready", {63'd0, bus.awready}, 64'd0);
        chk("rst_rvalid",  {63'd0, bus.rvalid},  64'd0);
        chk("rst_wready",  {63'd0, bus.wready},  64'd0);
        chk("rst_bvalid",  {63'd0, bus.bvalid},  64'd0);
        chk("rst_rdata",   bus.rdata, 64'd0);
        rst = 1'b1;
        rr_mode = 0;

        // single-beat write then read, with latency
        push_b(2'b00, 4'd1);
        send_aw(4'd1, 32'h80000000, 8'd0, 3'd3, 2'b01);
        send_w(64'h1122334455667788, 8'hFF, 1'b1);
        drain("t1_wr_drain");
        push_r(64'h1122334455667788, 2'b00, 1'b1, 4'd2);
        send_ar(4'd2, 32'h80000000, 8'd0, 3'd3, 2'b01);
        drain("t1_rd_drain");
        chk("t1_latency", 64'(t_rv - t_ar), 64'(RD_LAT + 1));

        // INCR burst of four, read back with rready toggling
        push_b(2'b00, 4'd3);
        send_aw(4'd3, 32'h80000010, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) send_w(d2[i], 8'hFF, i == 3);
        drain("t2_wr_drain");
        rr_mode = 1;
        for (int i = 0; i < 4; i++) push_r(d2[i], 2'b00, i == 3, 4'd4);
        send_ar(4'd4, 32'h80000010, 8'd3, 3'd3, 2'b01);
        drain("t2_rd_drain");
        rr_mode = 0;

        // byte store into lane 5 of word 0
        word0 = 64'h1122AB4455667788;
        push_b(2'b00, 4'd5);
        send_aw(4'd5, 32'h80000005, 8'd0, 3'd0, 2'b01);
        send_w(64'h0000AB0000000000, 8'h20, 1'b1);
        drain("t3_wr_drain");
        push_r(word0, 2'b00, 1'b1, 4'd6);
        send_ar(4'd6, 32'h80000000, 8'd0, 3'd3, 2'b01);
        drain("t3_rd_drain");

        // out-of-range read below BASE and write just past the top (which aliases word 0 if mis-decoded)
        push_r(64'd0, 2'b10, 1'b1, 4'd7);
        send_ar(4'd7, 32'h7FFFFFF8, 8'd0, 3'd3, 2'b01);
        drain("t4_rd_drain");
        push_b(2'b10, 4'd8);
        send_aw(4'd8, 32'h80080000, 8'd0, 3'd3, 2'b01);
        send_w(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1);
        drain("t4_wr_drain");
        push_r(word0, 2'b00, 1'b1, 4'd9);
        send_ar(4'd9, 32'h80000000, 8'd0, 3'd3, 2'b01);
        drain("t4_untouched");

        // early wlast on a three-beat burst, B held off by bready
        bus.bready = 1'b0;
        push_b(2'b10, 4'd10);
        send_aw(4'd10, 32'h80000100, 8'd2, 3'd3, 2'b01);
        send_w(64'h1111111111111111, 8'hFF, 1'b0);
        send_w(64'h2222222222222222, 8'hFF, 1'b1);
        repeat (2) @(negedge clk);
        chk("t5_bvalid_held", {63'd0, bus.bvalid}, 64'd1);
        chk("t5_aw_blocked", {63'd0, bus.awready}, 64'd0);
        @(posedge clk); #1;
        bus.bready = 1'b1;
        drain("t5_b_drain");
        push_r(64'h1111111111111111, 2'b00, 1'b0, 4'd11);
        push_r(64'h2222222222222222, 2'b00, 1'b1, 4'd11);
        send_ar(4'd11, 32'h80000100, 8'd1, 3'd3, 2'b01);
        drain("t5_rd_drain");
        push_b(2'b00, 4'd12);
        send_aw(4'd12, 32'h80000200, 8'd0, 3'd3, 2'b01);
        send_w(64'h3333333333333333, 8'hFF, 1'b1);
        drain("t5_next_aw");

        // reset in the middle of a four-beat read, then a fresh read
        rr_mode = 2;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        push_r(d2[0], 2'b00, 1'b0, 4'd13);
        send_ar(4'd13, 32'h80000010, 8'd3, 3'd3, 2'b01);
        wait_rvalid("t6_beat0_valid");
        @(posedge clk); #1;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        wait_rvalid("t6_beat1_valid");
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rvalid_async", {63'd0, bus.rvalid}, 64'd0);
        chk("t6_arready_rst", {63'd0, bus.arready}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_arready_release", {63'd0, bus.arready}, 64'd0);
        @(negedge clk);
        chk("t6_arready_next", {63'd0, bus.arready}, 64'd1);
        rr_mode = 0;
        push_r(d2[3], 2'b00, 1'b1, 4'd14);
        send_ar(4'd14, 32'h80000028, 8'd0, 3'd3, 2'b01);
        drain("t6_rd_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
